// File: rtl/mux_serializer16_pkg.sv
// Shared types and index helpers for the 16:1 mux serializer.
package mux_serializer16_pkg;

    typedef enum logic {
        StIdle,
        StShift
    } ser_state_e;

    // Index of the first bit presented for a word.
    function automatic int unsigned first_idx(input int unsigned width, input bit msb_first);
        return msb_first ? (width - 1) : 0;
    endfunction

    // Index of the final bit presented for a word.
    function automatic int unsigned final_idx(input int unsigned width, input bit msb_first);
        return msb_first ? 0 : (width - 1);
    endfunction

endpackage

// File: rtl/mux_serializer16_if.sv
// Word-in / bit-out handshake bundle for the serializer.
interface mux_serializer16_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic [SW-1:0]    out_sel;
    logic             out_last;
    logic             busy;

    // Serializer side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bit, out_sel, out_last, busy
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bit, out_sel, out_last, busy
    );
endinterface

// File: rtl/mux_serializer16_ser_bit_sel.sv
// WIDTH:1 bit selector with the strict contract y = a[s].
module ser_bit_sel #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SW    = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [SW-1:0]    s,
    output logic             y
);
    // Plain indexed select; bit order comes from the index alone.
    always_comb begin
        y = a[s];
    end
endmodule

// File: rtl/mux_serializer16.sv
// Parallel-to-serial stage: accepts one word, presents it one bit per beat.
module mux_serializer16
    import mux_serializer16_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    mux_serializer16_if.slave  bus
);
    localparam int unsigned SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SW-1:0] START = SW'(first_idx(WIDTH, MSB_FIRST));
    localparam logic [SW-1:0] LAST  = SW'(final_idx(WIDTH, MSB_FIRST));

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [SW-1:0]    idx_q, idx_d;
    logic             in_ready;
    logic             out_last;
    logic             sel_bit;

    // Next-state, handshake and index stepping.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        idx_d    = idx_q;
        out_last = (state_q == StShift) && (idx_q == LAST);
        // Ready while idle, or on the final beat being taken (zero-bubble reload).
        in_ready = !rst && ((state_q == StIdle) || (out_last && bus.out_ready));
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && in_ready) begin
                    word_d  = bus.in_data;
                    idx_d   = START;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (bus.out_ready) begin
                    if (out_last) begin
                        idx_d = START;
                        if (bus.in_valid) begin
                            word_d = bus.in_data;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d = MSB_FIRST ? (idx_q - SW'(1)) : (idx_q + SW'(1));
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, word and index registers; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            word_q  <= '0;
            idx_q   <= START;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    ser_bit_sel #(
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_bit_sel (
        .a (word_q),
        .s (idx_q),
        .y (sel_bit)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == StShift);
    assign bus.busy      = (state_q == StShift);
    assign bus.out_bit   = sel_bit;
    assign bus.out_sel   = idx_q;
    assign bus.out_last  = out_last;
endmodule

// File: tb/tb_mux_serializer16.sv
// Directed, table-driven bench for mux_serializer16 (LSB-first and MSB-first instances).
module tb_mux_serializer16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mux_serializer16_if #(.WIDTH(16)) if0 ();
    mux_serializer16_if #(.WIDTH(16)) if1 ();

    mux_serializer16 #(.WIDTH(16), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    mux_serializer16 #(.WIDTH(16), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic valid;
        logic ready;
        logic bit_o;
        logic [3:0] sel;
        logic last;
        logic busy;
    } outs_t;

    typedef struct {
        logic [15:0] word;
        bit          msb;      // 1: drive the MSB-first instance
        logic [15:0] exp_seq;  // exp_seq[i] = i-th emitted bit
        bit          stall;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w, input logic v, input logic [15:0] d, input logic r);
        if (w) begin
            if1.in_valid = v; if1.in_data = d; if1.out_ready = r;
        end else begin
            if0.in_valid = v; if0.in_data = d; if0.out_ready = r;
        end
    endtask

    function automatic outs_t get_out(input bit w);
        outs_t o;
        if (w) begin
            o = '{if1.out_valid, if1.in_ready, if1.out_bit, if1.out_sel, if1.out_last, if1.busy};
        end else begin
            o = '{if0.out_valid, if0.in_ready, if0.out_bit, if0.out_sel, if0.out_last, if0.busy};
        end
        return o;
    endfunction

    // Send one word and check every beat; optional pseudo-random out_ready stalls.
    task automatic send_word(input bit w, input logic [15:0] word, input logic [15:0] exp_seq,
                             input bit stall, input string tag);
        outs_t o;
        int    beat;
        int    cycles;
        logic  r;
        logic [31:0] pat;
        pat = $urandom;
        @(negedge clk);
        drive(w, 1'b1, word, 1'b1);
        #1;
        check($sformatf("%s accept_ready", tag), {31'd0, get_out(w).ready}, 32'd1);
        @(negedge clk);
        beat   = 0;
        cycles = 0;
        while (beat < 16 && cycles < 200) begin
            r = stall ? (pat[cycles % 32] | (cycles >= 40)) : 1'b1;
            drive(w, 1'b0, ~word, r);
            #1;
            o = get_out(w);
            check($sformatf("%s b%0d valid", tag, beat), {31'd0, o.valid}, 32'd1);
            check($sformatf("%s b%0d bit", tag, beat), {31'd0, o.bit_o}, {31'd0, exp_seq[beat]});
            check($sformatf("%s b%0d sel", tag, beat), {28'd0, o.sel},
                  w ? 32'(15 - beat) : 32'(beat));
            check($sformatf("%s b%0d last", tag, beat), {31'd0, o.last}, {31'd0, beat == 15});
            check($sformatf("%s b%0d in_ready", tag, beat), {31'd0, o.ready},
                  {31'd0, (beat == 15) && r});
            if (r) beat++;
            cycles++;
            @(negedge clk);
        end
        if (beat < 16) check($sformatf("%s timeout", tag), 32'(beat), 32'd16);
        drive(w, 1'b0, 16'h0, 1'b0);
        #1;
        o = get_out(w);
        check($sformatf("%s idle_valid", tag), {31'd0, o.valid}, 32'd0);
        check($sformatf("%s idle_busy", tag), {31'd0, o.busy}, 32'd0);
    endtask

    initial begin
        outs_t o;
        checks   = 0;
        failures = 0;
        vecs[0] = '{16'hA5C3, 1'b0, 16'hA5C3, 1'b0};
        vecs[1] = '{16'h8001, 1'b1, 16'h8001, 1'b0};
        vecs[2] = '{16'h1234, 1'b0, 16'h1234, 1'b1};
        vecs[3] = '{16'h1234, 1'b1, 16'h2C48, 1'b0};
        vecs[4] = '{16'h00F0, 1'b0, 16'h00F0, 1'b1};
        vecs[5] = '{16'h0F0F, 1'b1, 16'hF0F0, 1'b1};

        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 1'b0);

        // Reset: all outputs of the LSB-first instance held at zero.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            o = get_out(1'b0);
            check($sformatf("rst c%0d outs", c), {26'd0, o}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst in_ready", {31'd0, get_out(1'b0).ready}, 32'd1);
        check("post_rst out_valid", {31'd0, get_out(1'b0).valid}, 32'd0);
        check("post_rst msb sel", {28'd0, get_out(1'b1).sel}, 32'd15);

        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].msb, vecs[i].word, vecs[i].exp_seq, vecs[i].stall,
                      $sformatf("v%0d", i));
        end

        // Back-to-back FFFF then 0000 with in_valid held: 32 gapless beats.
        @(negedge clk);
        drive(1'b0, 1'b1, 16'hFFFF, 1'b1);
        #1;
        check("b2b accept", {31'd0, get_out(1'b0).ready}, 32'd1);
        for (int b = 0; b < 32; b++) begin
            @(negedge clk);
            drive(1'b0, (b < 31), 16'h0000, 1'b1);
            #1;
            o = get_out(1'b0);
            check($sformatf("b2b b%0d valid", b), {31'd0, o.valid}, 32'd1);
            check($sformatf("b2b b%0d bit", b), {31'd0, o.bit_o}, {31'd0, b < 16});
            check($sformatf("b2b b%0d sel", b), {28'd0, o.sel}, 32'(b % 16));
            check($sformatf("b2b b%0d in_ready", b), {31'd0, o.ready}, {31'd0, (b % 16) == 15});
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        check("b2b end valid", {31'd0, get_out(1'b0).valid}, 32'd0);

        // Reset pulsed at beat 7 of FFFF discards the word.
        @(negedge clk);
        drive(1'b0, 1'b1, 16'hFFFF, 1'b1);
        for (int b = 0; b < 7; b++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 16'h0, 1'b1);
            #1;
            check($sformatf("rstmid b%0d sel", b), {28'd0, get_out(1'b0).sel}, 32'(b));
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        o = get_out(1'b0);
        check("rstmid valid", {31'd0, o.valid}, 32'd0);
        check("rstmid busy", {31'd0, o.busy}, 32'd0);
        check("rstmid sel", {28'd0, o.sel}, 32'd0);
        send_word(1'b0, 16'h3C5A, 16'h3C5A, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
